// File: rtl/lsa_line_position.sv
// Line-sensor frame assembler: weights four ordered ADC samples into a signed
// line-position error, thresholds them into a bitmap and counts malformed frames.
module lsa_line_position #(
    parameter logic [11:0]        THRESH   = 12'd2048,
    parameter logic signed [15:0] LOST_MAG = 16'sd20000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sample_valid,
    input  logic [1:0]  sample_ch,
    input  logic [11:0] sample_data,
    output logic        frame_valid,
    output logic [15:0] position,
    output logic [3:0]  line_bits,
    output logic        line_lost,
    output logic        frame_err,
    output logic [7:0]  err_count
);

    // state   | meaning
    // IDLE    | waiting for ch0 to open a frame
    // COLLECT | frame open, waiting for expect_ch (1..3)
    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } state_t;

    state_t             state, state_next;
    logic signed [15:0] acc;
    logic [3:0]         bits;
    logic [1:0]         expect_ch;
    logic               last_dir;

    logic [15:0]        d1, d3;
    logic signed [15:0] term, acc_sum;
    logic               hit;
    logic [3:0]         hit_vec, bits_sum;
    logic               load_first, accumulate, publish, err;

    // x3 as d + 2d, no multiplier
    assign d1 = {4'b0000, sample_data};
    assign d3 = d1 + {3'b000, sample_data, 1'b0};
    assign hit = (sample_data >= THRESH);

    always_comb begin
        term    = '0;
        hit_vec = '0;
        case (sample_ch)
            2'd0:    term = -$signed(d3);
            2'd1:    term = -$signed(d1);
            2'd2:    term = $signed(d1);
            default: term = $signed(d3);
        endcase
        hit_vec[sample_ch] = hit;
    end

    assign acc_sum  = acc + term;
    assign bits_sum = bits | hit_vec;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        load_first = 1'b0;
        accumulate = 1'b0;
        publish    = 1'b0;
        err        = 1'b0;
        if (sample_valid) begin
            case (state)
                IDLE: begin
                    if (sample_ch == 2'd0) begin
                        load_first = 1'b1;
                        state_next = COLLECT;
                    end else begin
                        err = 1'b1;
                    end
                end
                default: begin
                    if (sample_ch == expect_ch) begin
                        accumulate = 1'b1;
                        if (sample_ch == 2'd3) begin
                            publish    = 1'b1;
                            state_next = IDLE;
                        end
                    end else if (sample_ch == 2'd0) begin
                        // a stray ch0 restarts the frame rather than being dropped
                        err        = 1'b1;
                        load_first = 1'b1;
                    end else begin
                        err        = 1'b1;
                        state_next = IDLE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_valid <= 1'b0;
            position    <= '0;
            line_bits   <= '0;
            line_lost   <= 1'b0;
            frame_err   <= 1'b0;
            err_count   <= '0;
            acc         <= '0;
            bits        <= '0;
            expect_ch   <= '0;
            last_dir    <= 1'b0;
        end else begin
            frame_valid <= publish;
            frame_err   <= err;
            if (err && err_count != 8'hFF) err_count <= err_count + 8'd1;

            if (load_first) begin
                acc       <= term;
                bits      <= hit_vec;
                expect_ch <= 2'd1;
            end else if (accumulate) begin
                acc       <= acc_sum;
                bits      <= bits_sum;
                expect_ch <= expect_ch + 2'd1;
            end else if (err) begin
                expect_ch <= 2'd0;
            end

            if (publish) begin
                line_bits <= bits_sum;
                if (bits_sum != 4'd0) begin
                    position  <= acc_sum;
                    line_lost <= 1'b0;
                    last_dir  <= acc_sum[15];
                end else begin
                    // line lost: steer hard toward the side it was last seen
                    position  <= last_dir ? -LOST_MAG : LOST_MAG;
                    line_lost <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_lsa_line_position.sv
// Scoreboard bench for lsa_line_position: directed frames plus randomized
// sample streams checked against a frame-level reference model.
module tb_lsa_line_position;

    logic        clk = 1'b0;
    logic        rst;
    logic        sample_valid;
    logic [1:0]  sample_ch;
    logic [11:0] sample_data;
    logic        frame_valid;
    logic [15:0] position;
    logic [3:0]  line_bits;
    logic        line_lost;
    logic        frame_err;
    logic [7:0]  err_count;

    always #5 clk = ~clk;

    lsa_line_position dut (
        .clk          (clk),
        .rst          (rst),
        .sample_valid (sample_valid),
        .sample_ch    (sample_ch),
        .sample_data  (sample_data),
        .frame_valid  (frame_valid),
        .position     (position),
        .line_bits    (line_bits),
        .line_lost    (line_lost),
        .frame_err    (frame_err),
        .err_count    (err_count)
    );

    typedef struct {
        logic [15:0] pos;
        logic [3:0]  bits;
        logic        lost;
    } frame_t;

    frame_t     fq[$];
    logic [7:0] eq[$];

    int checks = 0;
    int errors = 0;

    // reference model state: samples of the open frame, next channel wanted
    int m_s[4];
    int m_n;
    bit m_last_neg;
    int m_cnt;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endfunction

    function automatic void model_reset();
        m_n        = 0;
        m_last_neg = 1'b0;
        m_cnt      = 0;
    endfunction

    function automatic void model_err();
        m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
        eq.push_back(8'(m_cnt));
    endfunction

    function automatic void model_publish();
        frame_t f;
        int b;
        int p;
        b = 0;
        for (int i = 0; i < 4; i++)
            if (m_s[i] >= 2048) b = b | (1 << i);
        p = 3 * m_s[3] + m_s[2] - m_s[1] - 3 * m_s[0];
        f.bits = 4'(b);
        if (b != 0) begin
            f.pos      = 16'(p);
            f.lost     = 1'b0;
            m_last_neg = (p < 0);
        end else begin
            f.pos  = 16'(m_last_neg ? -20000 : 20000);
            f.lost = 1'b1;
        end
        fq.push_back(f);
    endfunction

    function automatic void model_sample(int ch, int d);
        if (m_n == 0) begin
            if (ch == 0) begin
                m_s[0] = d;
                m_n    = 1;
            end else begin
                model_err();
            end
        end else if (ch == m_n) begin
            m_s[ch] = d;
            m_n++;
            if (m_n == 4) begin
                model_publish();
                m_n = 0;
            end
        end else if (ch == 0) begin
            model_err();
            m_s[0] = d;
            m_n    = 1;
        end else begin
            model_err();
            m_n = 0;
        end
    endfunction

    // monitor: pops the scoreboard whenever the DUT pulses an output
    always @(negedge clk) begin
        if (frame_valid || frame_err)
            check("pulse_exclusive", {31'd0, frame_valid & frame_err}, 32'd0);
        if (frame_valid) begin
            check("frame_expected", {31'd0, fq.size() != 0}, 32'd1);
            if (fq.size() != 0) begin
                frame_t f;
                f = fq.pop_front();
                check("position",  {16'd0, position},  {16'd0, f.pos});
                check("line_bits", {28'd0, line_bits}, {28'd0, f.bits});
                check("line_lost", {31'd0, line_lost}, {31'd0, f.lost});
            end
        end
        if (frame_err) begin
            check("err_expected", {31'd0, eq.size() != 0}, 32'd1);
            if (eq.size() != 0) begin
                logic [7:0] e;
                e = eq.pop_front();
                check("err_count", {24'd0, err_count}, {24'd0, e});
            end
        end
    end

    task automatic send(input int ch, input int d);
        sample_valid = 1'b1;
        sample_ch    = 2'(ch);
        sample_data  = 12'(d);
        model_sample(ch, d);
        @(negedge clk);
        sample_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic frame(input int a, input int b, input int c, input int d);
        send(0, a);
        send(1, b);
        send(2, c);
        send(3, d);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_frame_valid"}, {31'd0, frame_valid}, 32'd0);
        check({tag, "_position"},    {16'd0, position},    32'd0);
        check({tag, "_line_bits"},   {28'd0, line_bits},   32'd0);
        check({tag, "_line_lost"},   {31'd0, line_lost},   32'd0);
        check({tag, "_frame_err"},   {31'd0, frame_err},   32'd0);
        check({tag, "_err_count"},   {24'd0, err_count},   32'd0);
    endtask

    // one-cycle reset with a ch0 strobe in the same cycle that must be ignored
    task automatic do_reset();
        rst          = 1'b1;
        sample_valid = 1'b1;
        sample_ch    = 2'd0;
        sample_data  = 12'd3000;
        model_reset();
        @(negedge clk);
        rst          = 1'b0;
        sample_valid = 1'b0;
        check_reset_outputs("after_rst");
        check("pending_after_rst", fq.size() + eq.size(), 32'd0);
    endtask

    initial begin
        rst          = 1'b1;
        sample_valid = 1'b0;
        sample_ch    = 2'd0;
        sample_data  = 12'd0;
        model_reset();
        idle(2);
        check_reset_outputs("reset");
        rst = 1'b0;
        idle(1);

        // basic frame, then lost line remembering a right-side line
        frame(100, 100, 3000, 100);
        check("t1_position", {16'd0, position}, {16'd0, 16'sd2900});
        idle(2);
        frame(100, 100, 100, 100);
        check("t3_lost_pos", {16'd0, position}, {16'd0, 16'sd20000});
        check("t3_lost_flag", {31'd0, line_lost}, 32'd1);

        // centred, far left, then lost on the left
        frame(3000, 3000, 3000, 3000);
        check("t2_centre", {16'd0, position}, 32'd0);
        send(0, 4095); idle(3); send(1, 0); send(2, 0); idle(1); send(3, 0);
        check("t2_left", {16'd0, position}, {16'd0, -16'sd12285});
        frame(100, 100, 100, 100);
        check("t3_lost_left", {16'd0, position}, {16'd0, -16'sd20000});

        // order errors
        send(0, 100); send(2, 100);
        idle(1);
        check("t4_err_count", {24'd0, err_count}, 32'd1);
        frame(100, 100, 3000, 100);
        send(0, 500); send(1, 500); send(0, 100);
        send(1, 100); send(2, 3000); send(3, 100);
        check("t5_restart_pos", {16'd0, position}, {16'd0, 16'sd2900});
        for (int i = 0; i < 300; i++) send(1 + $urandom_range(0, 2), $urandom_range(0, 4095));
        idle(2);
        check("t5_saturate", {24'd0, err_count}, 32'd255);

        // reset mid-frame
        send(0, 100); send(1, 100);
        do_reset();
        send(2, 3000); send(3, 100);
        idle(2);
        check("t6_err_count", {24'd0, err_count}, 32'd2);

        // randomized stream
        for (int i = 0; i < 4000; i++) begin
            int ch;
            int d;
            ch = ($urandom_range(0, 9) < 8) ? m_n : $urandom_range(0, 3);
            d  = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 2047) : $urandom_range(0, 4095);
            send(ch, d);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
            if ($urandom_range(0, 999) == 0) do_reset();
        end

        for (int i = 0; i < 10 && (fq.size() + eq.size()) != 0; i++) @(negedge clk);
        check("drain_frames", fq.size(), 32'd0);
        check("drain_errs", eq.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
